// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtract sequencer:
// controller state encodings and the default operand width.
package serial_sub_ctrl_pkg;

   // Default operand/result width in bits
   localparam int DEF_WIDTH = 8;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_sub_ctrl_pkg

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle for the bit-serial subtractor.
// The master issues start with operands; the slave reports busy/done and the result.
interface serial_sub_ctrl_if
   import serial_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );

endinterface : serial_sub_ctrl_if

// File: rtl/serial_sub_ctrl_full_sub.sv
// One-bit full subtractor cell: d = x - y - z, b = borrow out.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic d,
   output logic b
);

   // Difference and borrow of a single bit slice
   assign d = x ^ y ^ z;
   assign b = (~x & y) | (~x & z) | (y & z);

endmodule : full_sub

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract sequencer: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell. Results are registered and held until the
// next accepted operation finishes.
module serial_sub_ctrl
   import serial_sub_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic              clk,
   input logic              rst,
   serial_sub_ctrl_if.slave bus
);

   localparam int              CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res;
   logic             brw;
   logic [CNT_W-1:0] cnt;
   logic             a_msb;
   logic             b_msb;

   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;
   logic             ovf_r;

   logic             cell_d;
   logic             cell_b;
   logic [WIDTH-1:0] res_next;
   logic             accept;

   // Shift a new bit in at the MSB end; written as a function so WIDTH=1 needs no special slice
   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic msb);
      logic [WIDTH-1:0] r;
      r            = v >> 1;
      r[WIDTH-1]   = msb;
      return r;
   endfunction

   full_sub u_cell (
      .x (sh_a[0]),
      .y (sh_b[0]),
      .z (brw),
      .d (cell_d),
      .b (cell_b)
   );

   assign res_next = shift_in(res, cell_d);

   // A request is taken whenever the sequencer is not mid-operation (IDLE or DONE)
   assign accept = bus.start && (state != ST_RUN);

   // Controller FSM with operand shifters, borrow flop, bit counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         sh_a   <= '0;
         sh_b   <= '0;
         res    <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         diff_r <= '0;
         bout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            sh_a   <= bus.a;
            sh_b   <= bus.b;
            brw    <= bus.bin;
            cnt    <= '0;
            res    <= '0;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            state  <= ST_RUN;
            busy_r <= 1'b1;
         end else begin
            case (state)
               ST_RUN: begin
                  res  <= res_next;
                  sh_a <= sh_a >> 1;
                  sh_b <= sh_b >> 1;
                  brw  <= cell_b;
                  cnt  <= cnt + 1'b1;
                  if (cnt == LAST_BIT) begin
                     // Last bit: the cell's D is the result MSB, so overflow uses it directly
                     state  <= ST_DONE;
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     diff_r <= res_next;
                     bout_r <= cell_b;
                     ovf_r  <= (a_msb != b_msb) && (cell_d != a_msb);
                  end
               end
               ST_DONE: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.diff = diff_r;
   assign bus.bout = bout_r;
   assign bus.ovf  = ovf_r;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec8_t;

   typedef struct {
      logic a;
      logic b;
      logic bin;
      logic diff;
      logic bout;
      logic ovf;
   } vec1_t;

   logic clk = 1'b0;
   logic rst;

   int n_chk  = 0;
   int n_fail = 0;

   vec8_t tv8[8];
   vec1_t tv1[8];

   always #5 clk = ~clk;

   serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
   serial_sub_ctrl_if #(.WIDTH(1)) if1 ();

   serial_sub_ctrl #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (if8)
   );

   serial_sub_ctrl #(.WIDTH(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one WIDTH=8 operation from the current negedge and wait (bounded) for done.
   // Operands are scrambled right after acceptance; diff must still hold the previous result mid-run.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] prev_diff, output int lat);
      if8.a     = a;
      if8.b     = b;
      if8.bin   = bin;
      if8.start = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            if8.start = 1'b0;
            if8.a     = ~a;
            if8.b     = ~b;
            if8.bin   = ~bin;
         end
         if (lat == 4) begin
            check("busy_mid_run", {31'd0, if8.busy}, 32'd1);
            check("diff_held_mid_run", {24'd0, if8.diff}, {24'd0, prev_diff});
         end
      end while (!if8.done && lat < 20);
   endtask

   initial begin
      int lat;
      int done_cnt;
      int done_at;
      logic [7:0] prev;

      tv8[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      tv8[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
      tv8[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      tv8[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      tv8[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      tv8[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tv8[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
      tv8[7] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1};

      tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      rst       = 1'b1;
      if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
      if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_busy",  {31'd0, if8.busy}, 32'd0);
      check("rst_done",  {31'd0, if8.done}, 32'd0);
      check("rst_diff",  {24'd0, if8.diff}, 32'd0);
      check("rst_bout",  {31'd0, if8.bout}, 32'd0);
      check("rst_ovf",   {31'd0, if8.ovf},  32'd0);
      check("rst_busy1", {31'd0, if1.busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table of WIDTH=8 vectors, issued back to back
      prev = 8'h00;
      for (int i = 0; i < 8; i++) begin
         run8(tv8[i].a, tv8[i].b, tv8[i].bin, prev, lat);
         check($sformatf("latency_%0d", i), lat, 32'd9);
         check($sformatf("diff_%0d", i), {24'd0, if8.diff}, {24'd0, tv8[i].diff});
         check($sformatf("bout_%0d", i), {31'd0, if8.bout}, {31'd0, tv8[i].bout});
         check($sformatf("ovf_%0d", i),  {31'd0, if8.ovf},  {31'd0, tv8[i].ovf});
         check($sformatf("busy_at_done_%0d", i), {31'd0, if8.busy}, 32'd0);
         prev = tv8[i].diff;
      end
      @(negedge clk);
      check("done_single_cycle", {31'd0, if8.done}, 32'd0);
      check("idle_after_done",   {31'd0, if8.busy}, 32'd0);
      check("diff_hold_idle",    {24'd0, if8.diff}, 32'h80);

      // start during RUN with new operands must be ignored
      if8.a = 8'h05; if8.b = 8'h03; if8.bin = 1'b0; if8.start = 1'b1;
      done_cnt = 0;
      done_at  = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 1) if8.start = 1'b0;
         if (i == 3) begin
            if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h01;
         end
         if (i == 4) if8.start = 1'b0;
         if (i < 9) check($sformatf("busy_ignore_%0d", i), {31'd0, if8.busy}, 32'd1);
         if (if8.done) begin
            done_cnt++;
            if (done_at == 0) done_at = i;
         end
      end
      check("ignore_done_count", done_cnt, 32'd1);
      check("ignore_done_at",    done_at,  32'd9);
      check("ignore_diff",       {24'd0, if8.diff}, 32'h02);

      // Reset in the middle of a run aborts it
      if8.a = 8'h03; if8.b = 8'h05; if8.bin = 1'b0; if8.start = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) if8.start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", {31'd0, if8.busy}, 32'd0);
      check("midrst_diff", {24'd0, if8.diff}, 32'd0);
      check("midrst_done", {31'd0, if8.done}, 32'd0);
      done_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (if8.done) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 32'd0);
      run8(8'h03, 8'h05, 1'b0, 8'h00, lat);
      check("postrst_latency", lat, 32'd9);
      check("postrst_diff", {24'd0, if8.diff}, 32'hFE);
      check("postrst_bout", {31'd0, if8.bout}, 32'd1);

      // Reset and start in the same cycle: reset wins
      rst = 1'b1; if8.start = 1'b1; if8.a = 8'h11; if8.b = 8'h01;
      @(negedge clk);
      rst = 1'b0; if8.start = 1'b0;
      check("rst_start_busy", {31'd0, if8.busy}, 32'd0);
      check("rst_start_diff", {24'd0, if8.diff}, 32'd0);
      check("rst_start_bout", {31'd0, if8.bout}, 32'd0);
      @(negedge clk);
      check("rst_start_still_idle", {31'd0, if8.busy}, 32'd0);

      // WIDTH=1: all borrow combinations back to back, restarted from DONE
      if1.a = tv1[0].a; if1.b = tv1[0].b; if1.bin = tv1[0].bin; if1.start = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("w1_busy_%0d", k), {31'd0, if1.busy}, 32'd1);
         check($sformatf("w1_nodone_%0d", k), {31'd0, if1.done}, 32'd0);
         if (k < 7) begin
            if1.a = tv1[k+1].a; if1.b = tv1[k+1].b; if1.bin = tv1[k+1].bin;
         end else begin
            if1.start = 1'b0;
         end
         @(negedge clk);
         check($sformatf("w1_done_%0d", k), {31'd0, if1.done}, 32'd1);
         check($sformatf("w1_diff_%0d", k), {31'd0, if1.diff}, {31'd0, tv1[k].diff});
         check($sformatf("w1_bout_%0d", k), {31'd0, if1.bout}, {31'd0, tv1[k].bout});
         check($sformatf("w1_ovf_%0d", k),  {31'd0, if1.ovf},  {31'd0, tv1[k].ovf});
      end
      @(negedge clk);
      check("w1_idle_end", {31'd0, if1.busy}, 32'd0);
      check("w1_done_end", {31'd0, if1.done}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_serial_sub_ctrl
